// File: rtl/mem_bus_arbiter.sv
// Purpose: single-port memory bus arbiter between instruction fetch (IF) and load/store (LSU), plus global core_lock stall.
// Latency: grant cycle N -> bus_valid N+1; bus_ready at N+k -> owner ack at N+k+1 -> IDLE at N+k+2 (min req->ack 2 cycles).
// Backpressure: requesters hold req until ack; bus holds via bus_ready (optional timeout); core_lock stalls the pipeline meanwhile.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   if_req/if_addr/if_kill  -> if_ack/if_rdata/if_err        fetch side (read-only, full-width)
//   lsu_req/lsu_we/lsu_addr/lsu_wdata/lsu_wstrb/lsu_size -> lsu_ack/lsu_rdata/lsu_err
//   bus_valid/bus_we/bus_addr/bus_wdata/bus_wstrb/bus_size <- bus_ready/bus_rdata/bus_err
//   core_lock                                                 pipeline-wide stall
// Build option: define MEM_ARB_RR_EN for round-robin tie-break; otherwise LSU beats IF on a tie.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic [1:0]          lsu_size,
    output logic                lsu_ack,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    output logic                bus_valid,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [1:0]          bus_size,
    input  logic                bus_ready,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err,
    output logic                core_lock
);

    localparam int STRB_W = DATA_W / 8;
    // A zero TIMEOUT would give a zero-width counter; keep one bit so the logic stays legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                own_q, own_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                kill_q, kill_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic [1:0]          bus_size_q, bus_size_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                if_elig;
    logic                pick_lsu;
    logic                timeout_hit;

    // A fetch being redirected this very cycle is not worth starting.
    assign if_elig = if_req & ~if_kill;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef MEM_ARB_RR_EN
    // rr_q remembers the last granted owner; on a tie the other one wins.
    logic rr_q, rr_d;
    logic tie;

    assign tie      = if_elig & lsu_req;
    assign pick_lsu = tie ? (rr_q == OWN_IF) : lsu_req;
`else
    assign pick_lsu = lsu_req;
`endif

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_size_d  = bus_size_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef MEM_ARB_RR_EN
        rr_d        = rr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                kill_d = 1'b0;
                if (if_elig || lsu_req) begin
                    state_d = ST_BUS;
                    own_d   = pick_lsu;
`ifdef MEM_ARB_RR_EN
                    rr_d    = pick_lsu;
`endif
                    if (pick_lsu) begin
                        bus_we_d    = lsu_we;
                        bus_addr_d  = lsu_addr;
                        bus_wdata_d = lsu_wdata;
                        bus_wstrb_d = lsu_wstrb;
                        bus_size_d  = lsu_size;
                    end else begin
                        // Fetches are always full-width reads.
                        bus_we_d    = 1'b0;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        bus_wstrb_d = '0;
                        bus_size_d  = 2'b11;
                    end
                end
            end
            ST_BUS: begin
                // The transaction always runs to completion; a kill only hides the result.
                if (own_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (bus_ready) begin
                    rdata_d = bus_rdata;
                    err_d   = bus_err;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (own_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            own_q       <= OWN_IF;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_size_q  <= 2'b00;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q        <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_size_q  <= bus_size_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef MEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign bus_valid = (state_q == ST_BUS);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_size  = bus_size_q;

    // A kill arriving in the response cycle itself also suppresses the fetch ack.
    assign if_ack    = (state_q == ST_RESP) && (own_q == OWN_IF) && !kill_q && !if_kill;
    assign lsu_ack   = (state_q == ST_RESP) && (own_q == OWN_LSU);
    assign if_rdata  = if_ack  ? rdata_q : '0;
    assign if_err    = if_ack  & err_q;
    assign lsu_rdata = lsu_ack ? rdata_q : '0;
    assign lsu_err   = lsu_ack & err_q;

    // A killed fetch drops if_req, so it keeps the stall only through the BUS term.
    assign core_lock = (if_req & ~if_ack) | (lsu_req & ~lsu_ack) | (state_q == ST_BUS);

endmodule
